// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: pipelined single-transfer AHB-Lite master.
// Turns a valid/ready command stream into NONSEQ SINGLE transfers and returns
// read data / error status, in command order, on a valid/ready response stream.
//
// Ports
//   hclk, hresetn            clock, asynchronous active-low reset
//   cmd_valid/ready          command handshake (ready = address phase accepted)
//   cmd_write/addr/wdata     command payload
//   cmd_size                 transfer size (only with AHB_CMD_MASTER_SIZE_EN)
//   rsp_valid/ready          response handshake
//   rsp_rdata/err/write      response payload (head of the response FIFO)
//   busy                     data phase in flight or responses pending
//   haddr..hburst            AHB address/control/write-data outputs
//   hrdata, hresp, hready    AHB slave returns
//
// Optional feature macro: AHB_CMD_MASTER_SIZE_EN adds cmd_size and rejects
// misaligned or illegal-size commands without a bus transfer.

package ahb_cmd_master_pkg;
    localparam int unsigned data_w = 32;

    typedef struct packed {
        logic [data_w-1:0] rdata;
        logic              err;
        logic              write;
    } rsp_t;
endpackage

module ahb_cmd_master
    import ahb_cmd_master_pkg::*;
#(
    parameter int unsigned rsp_depth = 2,   // must be >= 2
    parameter int unsigned a_w       = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [a_w-1:0]    cmd_addr,
    input  logic [data_w-1:0] cmd_wdata,
`ifdef AHB_CMD_MASTER_SIZE_EN
    input  logic [2:0]        cmd_size,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [data_w-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_write,
    output logic              busy,
    output logic [a_w-1:0]    haddr,
    output logic [data_w-1:0] hwdata,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    input  logic [data_w-1:0] hrdata,
    input  logic [1:0]        hresp,
    input  logic              hready
);

    localparam int unsigned cnt_w = $clog2(rsp_depth + 1);
    localparam int unsigned ptr_w = (rsp_depth > 1) ? $clog2(rsp_depth) : 1;

    localparam logic [1:0] trans_idle   = 2'b00;
    localparam logic [1:0] trans_nonseq = 2'b10;
    localparam logic [1:0] resp_error   = 2'b01;
    localparam logic [2:0] size_word    = 3'b010;

    logic             run;
    logic             dp_valid;
    logic             dp_write;
    logic [cnt_w-1:0] fifo_cnt;
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    rsp_t             fifo_mem [rsp_depth];
    rsp_t             push_data;
    rsp_t             head;
    logic [cnt_w:0]   used;
    logic             push;
    logic             pop;
    logic             complete;
    logic             err_cancel;
    logic             can_issue;
    logic             issue;
    logic             accept;
    logic             reject;
    logic             bad;
    logic [2:0]       size_sel;
    logic             rej_valid;
    logic             rej_write;

    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(rsp_depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

`ifdef AHB_CMD_MASTER_SIZE_EN
    // Alignment / legality check of the presented command
    always_comb begin
        bad = 1'b0;
        case (cmd_size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = cmd_addr[0];
            3'd2:    bad = |cmd_addr[1:0];
            default: bad = 1'b1;
        endcase
    end

    assign size_sel = cmd_size;

    // Rejected command pushes its error response one cycle after acceptance
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rej_valid <= 1'b0;
            rej_write <= 1'b0;
        end else begin
            rej_valid <= reject;
            rej_write <= cmd_write;
        end
    end
`else
    assign bad       = 1'b0;
    assign size_sel  = size_word;
    assign rej_valid = 1'b0;
    assign rej_write = 1'b0;
`endif

    assign pop      = rsp_valid && rsp_ready;
    assign complete = dp_valid && hready;
    assign push     = complete || rej_valid;

    // Credit: a same-cycle pop frees its slot, so depth 2 sustains one transfer per cycle
    assign used = (cnt_w + 1)'(fifo_cnt) + (cnt_w + 1)'(dp_valid)
                + (cnt_w + 1)'(rej_valid) - (cnt_w + 1)'(pop);

    // First ERROR cycle: withdraw any pending address phase
    assign err_cancel = dp_valid && !hready && (hresp == resp_error);

    // run gates issuing so nothing is presented while (or right as) reset is active
    assign can_issue = run && (used < (cnt_w + 1)'(rsp_depth)) && !err_cancel;
    assign issue     = cmd_valid && can_issue && !bad;
    assign accept    = issue && hready;
    // Rejects wait for an empty data phase so responses stay in command order
    assign reject    = cmd_valid && can_issue && bad && !dp_valid;
    assign cmd_ready = accept || reject;

    // Address phase, combinational from the command inputs
    assign htrans = issue ? trans_nonseq : trans_idle;
    assign haddr  = issue ? cmd_addr : '0;
    assign hwrite = issue && cmd_write;
    assign hsize  = issue ? size_sel : size_word;
    assign hburst = 3'b000;

    // Response entry for the transfer completing (or the reject) this cycle
    always_comb begin
        push_data = '0;
        if (rej_valid) begin
            push_data.err   = 1'b1;
            push_data.write = rej_write;
        end else begin
            push_data.rdata = dp_write ? '0 : hrdata;
            push_data.err   = (hresp == resp_error);
            push_data.write = dp_write;
        end
    end

    // Data phase register; reload on completion gives back-to-back pipelining
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            run      <= 1'b0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            hwdata   <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                dp_valid <= 1'b1;
                dp_write <= cmd_write;
                hwdata   <= cmd_wdata;
            end else if (complete) begin
                dp_valid <= 1'b0;
            end
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + cnt_w'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - cnt_w'(1);
            end
        end
    end

    // Response FIFO storage
    always_ff @(posedge hclk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    // Head of FIFO; payload forced to zero while empty
    assign head      = fifo_mem[rd_ptr];
    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_rdata = rsp_valid ? head.rdata : '0;
    assign rsp_err   = rsp_valid && head.err;
    assign rsp_write = rsp_valid && head.write;
    assign busy      = dp_valid || rsp_valid || rej_valid;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Self-checking bench for ahb_cmd_master (default build).
// A behavioural AHB slave with per-command wait states / ERROR injection
// drives hready/hresp/hrdata; expected responses go into a scoreboard queue
// when a command is accepted and are compared when the DUT pops them.
module tb_ahb_cmd_master;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned ws;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        write;
    } exp_t;

    logic        hclk    = 1'b0;
    logic        hresetn = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_write, busy;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hready;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;

    always #5 hclk = ~hclk;

    ahb_cmd_master #(.rsp_depth(2), .a_w(32)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_write(rsp_write), .busy(busy),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst),
        .hrdata(hrdata), .hresp(hresp), .hready(hready)
    );

    // Slave read data as a function of address
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h0001_0000) return 32'h1234_5678;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Behavioural slave
    int unsigned ws_cfg = 0;
    logic        err_cfg = 1'b0;
    logic        s_act, s_write, s_err, s_errph;
    logic [31:0] s_addr;
    int unsigned s_cnt;

    assign hready = !s_act || (s_err ? s_errph : (s_cnt == 0));
    assign hresp  = (s_act && s_err) ? 2'b01 : 2'b00;
    assign hrdata = (s_act && !s_write) ? rd_val(s_addr) : 32'hDEAD_BEEF;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s_act <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_errph <= 1'b0;
            s_addr <= 32'h0; s_cnt <= 0;
        end else if (hready) begin
            if (htrans == 2'b10) begin
                s_act <= 1'b1; s_write <= hwrite; s_addr <= haddr;
                s_cnt <= ws_cfg; s_err <= err_cfg; s_errph <= 1'b0;
            end else begin
                s_act <= 1'b0;
            end
        end else if (s_err) begin
            s_errph <= 1'b1;
        end else begin
            s_cnt <= s_cnt - 1;
        end
    end

    int          n_vec = 0;
    int          n_bad = 0;
    cmd_t        cq[$];
    exp_t        eq[$];
    logic [31:0] wq[$];
    logic        acc_last = 1'b0;
    int          acc_total = 0;
    int          err_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_haddr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input int unsigned ws, input logic e,
                                input logic [31:0] er, input logic ee);
        cmd_t c;
        c.write = w; c.addr = a; c.wdata = d; c.ws = ws; c.err = e;
        c.exp_rdata = er; c.exp_err = ee;
        return c;
    endfunction

    task automatic drive();
        if (cq.size() != 0) begin
            cmd_valid = 1'b1; cmd_write = cq[0].write; cmd_addr = cq[0].addr;
            cmd_wdata = cq[0].wdata; ws_cfg = cq[0].ws; err_cfg = cq[0].err;
        end else begin
            cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
            cmd_wdata = 32'h0; ws_cfg = 0; err_cfg = 1'b0;
        end
    endtask

    // One clock: present command, monitor at negedge, return #1 after posedge
    task automatic tick();
        cmd_t c;
        exp_t e;
        drive();
        @(negedge hclk);
        acc_last = 1'b0;
        if (hresetn) begin
            if (rsp_valid && rsp_ready) begin
                if (eq.size() == 0) fail_now("rsp_unexpected");
                else begin
                    e = eq.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_write", 32'(rsp_write), 32'(e.write));
                end
            end
            if (s_act && s_write) begin
                if (wq.size() == 0) fail_now("hwdata_no_expect");
                else begin
                    chk("hwdata", hwdata, wq[0]);
                    if (hready) void'(wq.pop_front());
                end
            end
            if (prev_stall && s_act && !hready) chk("haddr_stable", haddr, prev_haddr);
            if (s_act && s_err && !s_errph) begin
                err_seen++;
                chk("err_cancel_htrans", 32'(htrans), 32'(2'b00));
                chk("err_cancel_ready", 32'(cmd_ready), 32'(1'b0));
            end
            if (cmd_valid && cmd_ready && cq.size() != 0) begin
                c = cq.pop_front();
                acc_last = 1'b1;
                acc_total++;
                chk("htrans_nonseq", 32'(htrans), 32'(2'b10));
                chk("haddr", haddr, c.addr);
                chk("hwrite", 32'(hwrite), 32'(c.write));
                chk("hsize", 32'(hsize), 32'(3'b010));
                chk("hburst", 32'(hburst), 32'(3'b000));
                e.rdata = c.exp_rdata; e.err = c.exp_err; e.write = c.write;
                eq.push_back(e);
                if (c.write) wq.push_back(c.wdata);
            end
            prev_stall = s_act && !hready;
            prev_haddr = haddr;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((cq.size() != 0 || eq.size() != 0 || busy) && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) fail_now("drain_timeout");
    endtask

    vec_t vt [7];

    initial begin
        int lat;
        logic got;
        int cons;
        int a0;
        int e0;
        logic seen;

        vt[0].c = mk(1'b1, 32'h0000_0000, 32'h0000_00A5, 0, 1'b0, 32'h0000_0000, 1'b0); vt[0].lat = 2;
        vt[1].c = mk(1'b0, 32'h0001_0000, 32'h0,         3, 1'b0, 32'h1234_5678, 1'b0); vt[1].lat = 5;
        vt[2].c = mk(1'b0, 32'h0000_0040, 32'h0,         0, 1'b0, 32'h0040_FFBF, 1'b0); vt[2].lat = 2;
        vt[3].c = mk(1'b1, 32'h0000_1004, 32'hDEAD_0001, 2, 1'b0, 32'h0000_0000, 1'b0); vt[3].lat = 4;
        vt[4].c = mk(1'b0, 32'h8000_0000, 32'h0,         1, 1'b0, 32'h0000_FFFF, 1'b0); vt[4].lat = 3;
        vt[5].c = mk(1'b1, 32'h0000_0FF0, 32'h5A5A_5A5A, 0, 1'b1, 32'h0000_0000, 1'b1); vt[5].lat = 3;
        vt[6].c = mk(1'b0, 32'h0000_0FF4, 32'h0,         0, 1'b1, 32'h0FF4_F00B, 1'b1); vt[6].lat = 3;

        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h77;
        #3 hresetn = 1'b0;
        @(posedge hclk); #1;
        // Reset state, with a command already presented
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'(1'b0));
        chk("rst_rsp_write", 32'(rsp_write), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_hwrite", 32'(hwrite), 32'(1'b0));
        chk("rst_htrans", 32'(htrans), 32'(2'b00));
        chk("rst_hsize", 32'(hsize), 32'(3'b010));
        chk("rst_hburst", 32'(hburst), 32'(3'b000));
        drive();
        @(posedge hclk); #1;
        hresetn = 1'b1;
        tick();
        tick();

        // Single transfers from the table, with response latency
        for (int i = 0; i < 7; i++) begin
            cq.push_back(vt[i].c);
            lat = 0;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                lat++;
                if (rsp_valid) got = 1'b1;
            end
            if (!got) fail_now("rsp_timeout");
            else chk("latency", 32'(lat), 32'(vt[i].lat));
            drain();
        end

        // Back-to-back: 4 writes then 4 reads, one accept per cycle
        for (int i = 0; i < 4; i++)
            cq.push_back(mk(1'b1, 32'h0000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 0, 1'b0, 32'h0, 1'b0));
        for (int i = 0; i < 4; i++)
            cq.push_back(mk(1'b0, 32'h0000_0200 + 32'(4 * i), 32'h0, 0, 1'b0,
                            rd_val(32'h0000_0200 + 32'(4 * i)), 1'b0));
        cons = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (acc_last) cons++;
        end
        chk("b2b_accepts", 32'(cons), 32'd8);
        drain();

        // Credit limit: rsp_ready low, 3 reads queued, only 2 issue
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cq.push_back(mk(1'b0, 32'h0000_0300 + 32'(4 * i), 32'h0, 0, 1'b0,
                            rd_val(32'h0000_0300 + 32'(4 * i)), 1'b0));
        a0 = acc_total;
        for (int k = 0; k < 6; k++) tick();
        chk("credit_issued", 32'(acc_total - a0), 32'd2);
        chk("credit_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        chk("credit_rsp_valid", 32'(rsp_valid), 32'(1'b1));
        chk("credit_busy", 32'(busy), 32'(1'b1));
        rsp_ready = 1'b1;
        tick();
        chk("credit_third_on_pop", 32'(acc_last), 32'(1'b1));
        drain();
        chk("credit_total", 32'(acc_total - a0), 32'd3);

        // ERROR on a write while a read waits behind it
        e0 = err_seen;
        cq.push_back(mk(1'b1, 32'h0000_2000, 32'h1111_2222, 0, 1'b1, 32'h0, 1'b1));
        cq.push_back(mk(1'b0, 32'h0000_2004, 32'h0, 0, 1'b0, rd_val(32'h0000_2004), 1'b0));
        drain();
        chk("err_first_cycle_seen", 32'(err_seen - e0), 32'd1);

        // Reset while a read data phase is stalled
        cq.push_back(mk(1'b0, 32'h0000_3000, 32'h0, 5, 1'b0, rd_val(32'h0000_3000), 1'b0));
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (s_act) got = 1'b1;
        end
        if (!got) fail_now("stall_start_timeout");
        tick();
        cq.push_back(mk(1'b0, 32'h0000_3008, 32'h0, 0, 1'b0, rd_val(32'h0000_3008), 1'b0));
        drive();
        #1;
        chk("pre_rst_htrans", 32'(htrans), 32'(2'b10));
        hresetn = 1'b0;
        #1;
        chk("midrst_htrans", 32'(htrans), 32'(2'b00));
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("midrst_busy", 32'(busy), 32'(1'b0));
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        cq.delete();
        eq.delete();
        wq.delete();
        prev_stall = 1'b0;
        drive();
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("no_rsp_after_reset", 32'(seen), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
